// File: rtl/wb_ctrl_if.sv
// Bundle of the wb_ctrl source, load-return and register-file write signals.
// The master side drives the ALU/load/memory inputs; the slave side is the controller.
interface wb_ctrl_if #(
    parameter int pw = 4
) ();
    logic              alu_vld;
    logic [pw-1:0]     alu_dst;
    logic [7:0]        alu_dat;
    logic              ld_issue;
    logic [pw-1:0]     ld_dst;
    logic              mem_vld;
    logic [7:0]        mem_dat;
    logic              wr_en;
    logic [pw-1:0]     wr_addr;
    logic [7:0]        wr_dat;
    logic              stall;
    logic [2**pw-1:0]  pend;
    logic              ld_timeout;
    // 1 while the controller is waiting on a load return
    logic              dbg_state;

    // Handshake: alu_vld / ld_issue are taken in any cycle where stall=0;
    // while stall=1 nothing is taken and upstream holds its inputs unchanged.
    modport master (
        output alu_vld, alu_dst, alu_dat, ld_issue, ld_dst, mem_vld, mem_dat,
        input  wr_en, wr_addr, wr_dat, stall, pend, ld_timeout, dbg_state
    );

    modport slave (
        input  alu_vld, alu_dst, alu_dat, ld_issue, ld_dst, mem_vld, mem_dat,
        output wr_en, wr_addr, wr_dat, stall, pend, ld_timeout, dbg_state
    );
endinterface

// File: rtl/wb_ctrl.sv
// Register-file write-back controller: merges ALU results with a single
// outstanding memory load, with a one-entry skid buffer and a load timeout.
module wb_ctrl #(
    parameter int pw      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      reset,
    wb_ctrl_if.slave  bus
);
    localparam int nreg = 2**pw;
    localparam int cw   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [pw-1:0]     ld_dst_q;
    logic [cw-1:0]     wait_cnt;
    logic [nreg-1:0]   pend_q;
    logic              timeout_q;
    logic              skid_full;
    logic [pw-1:0]     skid_addr;
    logic [7:0]        skid_dat;
    logic              wr_en_q;
    logic [pw-1:0]     wr_addr_q;
    logic [7:0]        wr_dat_q;

    logic stall;
    logic alu_acc;
    logic ld_acc;
    logic ld_ret;
    logic ld_expire;

    // A held skid entry blocks everything so it drains before any new ALU result.
    assign stall = skid_full
                 | (bus.ld_issue & (state == LD_WAIT))
                 | (bus.alu_vld & pend_q[bus.alu_dst]);

    assign alu_acc   = bus.alu_vld & ~stall;
    assign ld_acc    = bus.ld_issue & ~stall;
    assign ld_ret    = (state == LD_WAIT) & bus.mem_vld;
    assign ld_expire = (state == LD_WAIT) & ~bus.mem_vld & (wait_cnt == cw'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ld_dst_q  <= '0;
            wait_cnt  <= '0;
            pend_q    <= '0;
            timeout_q <= 1'b0;
            skid_full <= 1'b0;
            skid_addr <= '0;
            skid_dat  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;

            // Write port priority: load return, then skid drain, then a fresh ALU result.
            if (ld_ret) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ld_dst_q;
                wr_dat_q  <= bus.mem_dat;
                if (alu_acc) begin
                    skid_full <= 1'b1;
                    skid_addr <= bus.alu_dst;
                    skid_dat  <= bus.alu_dat;
                end
            end else if (skid_full) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= skid_addr;
                wr_dat_q  <= skid_dat;
                skid_full <= 1'b0;
            end else if (alu_acc) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= bus.alu_dst;
                wr_dat_q  <= bus.alu_dat;
            end

            case (state)
                IDLE: begin
                    if (ld_acc) begin
                        ld_dst_q             <= bus.ld_dst;
                        pend_q[bus.ld_dst]   <= 1'b1;
                        wait_cnt             <= '0;
                        state                <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (ld_ret) begin
                        pend_q[ld_dst_q] <= 1'b0;
                        state            <= IDLE;
                    end else if (ld_expire) begin
                        pend_q[ld_dst_q] <= 1'b0;
                        timeout_q        <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall      = stall;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_dat     = wr_dat_q;
    assign bus.pend       = pend_q;
    assign bus.ld_timeout = timeout_q;
    assign bus.dbg_state  = (state == LD_WAIT);

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus held-on-stall random traffic,
// scored against a write-queue reference model.
module tb_wb_ctrl;
  localparam int PW   = 4;
  localparam int TO   = 15;
  localparam int NREG = 2**PW;
  localparam int SW   = 20;
  localparam int W    = SW + PW + 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_ctrl_if #(.pw(PW)) bus ();

  wb_ctrl #(.pw(PW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Scoreboard: {cycle stamp, addr, data} of each expected register-file write
  logic [W-1:0] exp_q[$];

  // Reference model: at most one outstanding load, writes retire one per cycle in order
  bit              m_load_out;
  int              m_load_dst;
  int              m_age;
  bit              m_to;
  logic [PW+7:0]   m_wq[$];
  bit              last_stall;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    m_load_out = 0;
    m_load_dst = 0;
    m_age = 0;
    m_to = 0;
    m_wq.delete();
    exp_q.delete();
  endtask

  // Drive one cycle of inputs (called at negedge), check combinational outputs, advance model.
  task automatic step(input bit av, input int ad, input int adat,
                      input bit li, input int ldd, input bit mv, input int md);
    bit              exp_stall;
    bit              alu_ok;
    logic [NREG-1:0] exp_pend;
    logic [PW+7:0]   e;
    bus.alu_vld  = av;
    bus.alu_dst  = PW'(ad);
    bus.alu_dat  = 8'(adat);
    bus.ld_issue = li;
    bus.ld_dst   = PW'(ldd);
    bus.mem_vld  = mv;
    bus.mem_dat  = 8'(md);
    #1;
    exp_stall = (m_wq.size() > 0) || (li && m_load_out) ||
                (av && m_load_out && (PW'(ad) == PW'(m_load_dst)));
    exp_pend  = m_load_out ? (NREG'(1) << m_load_dst) : '0;
    chk("stall", bus.stall, exp_stall);
    chk("pend", bus.pend, exp_pend);
    chk("ld_timeout", bus.ld_timeout, m_to);
    chk("dbg_state", bus.dbg_state, m_load_out);
    last_stall = exp_stall;
    alu_ok = av && !exp_stall;
    if (m_load_out) begin
      if (mv) begin
        m_wq.push_back({PW'(m_load_dst), 8'(md)});
        m_load_out = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_load_out = 0;
          m_to = 1;
        end
      end
    end
    if (alu_ok) m_wq.push_back({PW'(ad), 8'(adat)});
    if (li && !exp_stall) begin
      m_load_out = 1;
      m_load_dst = ldd % NREG;
      m_age = 0;
    end
    if (m_wq.size() > 0) begin
      e = m_wq.pop_front();
      exp_q.push_back({SW'(cyc + 1), e});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset();
    bus.alu_vld = 0; bus.alu_dst = '0; bus.alu_dat = '0;
    bus.ld_issue = 0; bus.ld_dst = '0; bus.mem_vld = 0; bus.mem_dat = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_dat", bus.wr_dat, 0);
    chk("rst_pend", bus.pend, 0);
    chk("rst_ld_timeout", bus.ld_timeout, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_state", bus.dbg_state, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every write (or expected write) is compared against the queue head.
  always @(negedge clk) begin
    logic [W-1:0] head;
    bit           exp_wr;
    exp_wr = 0;
    head = '0;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        exp_wr = (int'(head[W-1 -: SW]) == cyc);
      end
      if (bus.wr_en || exp_wr) begin
        chk("wr_en", bus.wr_en, exp_wr);
        if (exp_wr) begin
          void'(exp_q.pop_front());
          if (bus.wr_en) begin
            chk("wr_addr", bus.wr_addr, head[PW+7:8]);
            chk("wr_dat", bus.wr_dat, head[7:0]);
          end
        end
      end
    end
  end

  initial begin
    bit av, li;
    int ad, adat, ldd;
    bus.alu_vld = 0; bus.alu_dst = '0; bus.alu_dat = '0;
    bus.ld_issue = 0; bus.ld_dst = '0; bus.mem_vld = 0; bus.mem_dat = '0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_reset();

    // ALU write in IDLE
    step(1, 3, 8'h5A, 0, 0, 0, 0);
    idle(2);
    // Load to r7 returning four cycles later
    step(0, 0, 0, 1, 7, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 8'hC3);
    idle(2);
    // Load return colliding with an ALU result: skid path
    step(0, 0, 0, 1, 2, 0, 0);
    idle(1);
    step(1, 5, 8'h22, 0, 0, 1, 8'h11);
    idle(3);
    // ALU to a pending register stalls until the load returns
    step(0, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 8'h99, 0, 0, 0, 0);
    step(1, 7, 8'h99, 0, 0, 1, 8'h44);
    step(1, 7, 8'h99, 0, 0, 0, 0);
    idle(2);
    // ALU and load issued together, same destination
    step(1, 6, 8'hA1, 1, 6, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 8'hB2);
    idle(2);
    // Timeout, then a new load is accepted and returns
    step(0, 0, 0, 1, 9, 0, 0);
    idle(TO);
    step(0, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8'h66);
    idle(2);
    // Reset mid-LD_WAIT discards the load
    step(0, 0, 0, 1, 2, 0, 0);
    idle(2);
    apply_reset();
    step(0, 0, 0, 0, 0, 1, 8'h77);
    idle(2);

    // Random traffic; upstream holds ALU/load inputs while stalled
    av = 0; li = 0; ad = 0; adat = 0; ldd = 0;
    last_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        av   = ($urandom_range(0, 1) == 1);
        ad   = $urandom_range(0, 3);
        adat = $urandom_range(0, 255);
        li   = ($urandom_range(0, 7) == 0);
        ldd  = $urandom_range(0, 3);
      end
      step(av, ad, adat, li, ldd, ($urandom_range(0, 5) == 0), $urandom_range(0, 255));
    end
    idle(TO + 4);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have parameter pw, default 4, meaning register address width (2**pw registers).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning maximum LD_WAIT cycles before a load is abandoned.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port alu_vld, input, 1, meaning an ALU result is offered this cycle.
REQ-006 SHALL have port alu_dst, input, pw, meaning the ALU destination register.
REQ-007 SHALL have port alu_dat, input, 8, meaning the ALU result.
REQ-008 SHALL have port ld_issue, input, 1, meaning a memory load is issued this cycle.
REQ-009 SHALL have port ld_dst, input, pw, meaning the load destination register.
REQ-010 SHALL have port mem_vld, input, 1, meaning load return data is valid.
REQ-011 SHALL have port mem_dat, input, 8, meaning load return data.
REQ-012 SHALL have port wr_en, output, 1, the register-file write enable.
REQ-013 SHALL have port wr_addr, output, pw, the register-file write address.
REQ-014 SHALL have port wr_dat, output, 8, the register-file write data.
REQ-015 SHALL have port stall, output, 1, meaning no input is accepted this cycle.
REQ-016 SHALL have port pend, output, 2**pw, one bit per register with an outstanding load.
REQ-017 SHALL have port ld_timeout, output, 1, a sticky flag set when a load is abandoned.

Function
REQ-018 SHALL drive wr_en, wr_addr and wr_dat from flops; an accepted source appears on them exactly 1 cycle after acceptance, and wr_en is high for exactly 1 cycle per write.
REQ-019 SHALL have a two-state FSM: IDLE and LD_WAIT.
REQ-020 SHALL compute stall combinationally as skid_full OR (ld_issue AND state==LD_WAIT) OR (alu_vld AND pend[alu_dst]).
REQ-021 SHALL accept neither alu_vld nor ld_issue in a cycle with stall=1; upstream holds its inputs.
REQ-022 SHALL, in IDLE with ld_issue and no stall, latch ld_dst, set pend[ld_dst], clear the wait counter and go to LD_WAIT.
REQ-023 SHALL ignore mem_vld in IDLE, including in the same cycle as ld_issue.
REQ-024 SHALL, in LD_WAIT with mem_vld, write mem_dat to the latched ld_dst the next cycle, clear its pend bit and return to IDLE.
REQ-025 SHALL, in LD_WAIT without mem_vld, increment the wait counter; when the count reaches TIMEOUT, it SHALL clear the pend bit, set ld_timeout, perform no write and return to IDLE.
REQ-026 SHALL accept ALU results in both states, so ALU writes may complete out of order with an outstanding load.
REQ-027 SHALL give the load priority when mem_vld (in LD_WAIT) and an accepted alu_vld coincide: the load is written at N+1, the ALU result is captured in a 1-entry skid buffer and written at N+2, and skid_full is 1 during N+1.
REQ-028 SHALL accept both inputs when alu_vld and ld_issue coincide in IDLE without stall: the ALU result is written at N+1 and the load proceeds normally; the same destination is allowed, and the load data overwrites it later.
REQ-029 SHALL perform a drained skid write before any newly accepted ALU result.
REQ-030 SHALL produce no write from ld_issue while in LD_WAIT; the stall covers this case.

Reset
REQ-031 SHALL, on reset assertion and independent of clk: state=IDLE, wr_en=0, wr_addr=0, wr_dat=0, pend=0, skid empty, wait counter=0, ld_timeout=0.
REQ-032 SHALL, on reset during LD_WAIT or with a skid entry held, discard the pending work with no write after reset deasserts.
REQ-033 SHALL clear ld_timeout only by reset.

Verification
REQ-034 SHALL cover: ALU alu_vld=1, alu_dst=3, alu_dat=0x5A in IDLE -> next cycle wr_en=1, wr_addr=3, wr_dat=0x5A; following cycle wr_en=0.
REQ-035 SHALL cover: ld_issue with ld_dst=7, mem_vld 4 cycles later with mem_dat=0xC3 -> pend[7]=1 until the write, then wr_addr=7, wr_dat=0xC3 and pend=0.
REQ-036 SHALL cover: in LD_WAIT (ld_dst=2), mem_vld=0x11 and alu_vld dst=5 dat=0x22 same cycle -> N+1 write 2/0x11 with stall=1, N+2 write 5/0x22.
REQ-037 SHALL cover: alu_vld with alu_dst=7 while pend[7]=1 -> stall=1 and no write until the load returns.
REQ-038 SHALL cover: ld_issue with no mem_vld for 15 cycles -> ld_timeout=1, pend cleared, no write, state IDLE; a following ld_issue is accepted.
REQ-039 SHALL cover: reset asserted mid-LD_WAIT, then mem_vld -> no write, all outputs zero.
